// File: rtl/array_ctrl_pkg.sv
// Shared defaults and controller state type for the single-port array controller.
package array_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/array_resp_fifo.sv
// In-order read-response buffer: circular storage with push, pop, occupancy count and head data.
module array_resp_fifo #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Payload storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/array_rw_ctrl.sv
// Request/response front end for a single-port SRAM; optional power-up zero sweep
// of the whole array when ARRAY_CTRL_INIT_EN is defined.
module array_rw_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              init_done
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    occupancy_s;
  logic              ready_core_s;
  logic              fire_core_s;
  logic              fire_s;
  logic              pop_s;
  logic              inflight_r;
  logic              init_wr_s;
  logic [ADDR_W-1:0] init_addr_s;

`ifdef ARRAY_CTRL_INIT_EN
  ctrl_state_e       state_r;
  ctrl_state_e       state_next_s;
  logic [ADDR_W-1:0] init_cnt_r;

  // Controller state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Leave the sweep once the top address has been written
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (init_cnt_r == {ADDR_W{1'b1}}) begin
          state_next_s = RUN;
        end else begin
          state_next_s = INIT;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase
  end

  // Sweep address counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_r <= '0;
    end else if (state_r == INIT) begin
      init_cnt_r <= init_cnt_r + ADDR_W'(1);
    end
  end

  assign init_done   = (state_r == RUN);
  assign init_wr_s   = reset_n && (state_r == INIT);
  assign init_addr_s = init_cnt_r;
`else
  assign init_done   = 1'b1;
  assign init_wr_s   = 1'b0;
  assign init_addr_s = '0;
`endif

  // Each inflight read already owns a FIFO slot, so the buffer can never overflow.
  // reset_n only gates the outputs; flop inputs use the ungated fire.
  assign occupancy_s  = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};
  assign ready_core_s = init_done && (occupancy_s < (CNT_W + 1)'(RESP_DEPTH));
  assign req_ready    = reset_n && ready_core_s;
  assign fire_core_s  = req_valid && ready_core_s;
  assign fire_s       = req_valid && req_ready;
  assign resp_valid   = (count_s != '0);
  assign pop_s        = resp_valid && resp_ready;

  // Array port mux: sweep write, accepted request, or idle
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    if (init_wr_s) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_addr_s;
      RW0_wdata = '0;
    end else if (fire_s) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
      RW0_wdata = req_wdata;
    end else begin
      RW0_en    = 1'b0;
    end
  end

  // Marks the cycle in which array read data is valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fire_core_s && !req_write;
    end
  end

  array_resp_fifo #(
    .DEPTH  (RESP_DEPTH),
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_r),
    .push_data (RW0_rdata),
    .pop       (pop_s),
    .count     (count_s),
    .head      (resp_rdata)
  );

endmodule

// File: doc/array_rw_ctrl.md
ARRAY_RW_CTRL -- requirements
Module: array_rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have parameter RESP_DEPTH, default 3, read-response buffer entries (minimum 2).
REQ-004 SHALL have port clock  input  1  sole clock; every register is rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid/req_ready  input/output  1  request handshake.
REQ-007 SHALL have ports req_write  input  1 (1 = write), req_addr  input  ADDR_W, req_wdata  input  DATA_W.
REQ-008 SHALL have ports resp_valid/resp_ready  output/input  1, and resp_rdata  output  DATA_W, the read response.
REQ-009 SHALL have ports RW0_addr  output  ADDR_W, RW0_en  output  1, RW0_wmode  output  1, RW0_wdata  output  DATA_W, which drive the single-port array.
REQ-010 SHALL have port RW0_rdata  input  DATA_W, array read data, valid the cycle after a read enable.
REQ-011 SHALL have port init_done  output  1, high when the array is ready for requests.

Function
REQ-012 SHALL accept a request (fire) in a cycle with req_valid && req_ready.
REQ-013 SHALL compute req_ready = init_done && (count + inflight < RESP_DEPTH), with no combinational path from req_valid, req_write or resp_ready.
REQ-014 SHALL, on fire, drive RW0_en=1, RW0_wmode=req_write, RW0_addr=req_addr, RW0_wdata=req_wdata in the same cycle, combinationally.
REQ-015 SHALL hold RW0_en=0 in every cycle without a fire or init write.
REQ-016 SHALL set the 1-bit inflight register on a read fire and clear it the next cycle.
REQ-017 SHALL push RW0_rdata into the response FIFO in the cycle inflight=1, and only then, so a write issued in that cycle cannot corrupt the captured data.
REQ-018 SHALL produce no response for writes.
REQ-019 SHALL return read responses in issue order; resp_valid = (count != 0); resp_rdata = FIFO head; pop on resp_valid && resp_ready.
REQ-020 SHALL support a simultaneous push and pop, leaving count unchanged.
REQ-021 SHALL sustain one read per cycle with resp_ready held high, giving a 2-cycle fire-to-resp_valid latency.
REQ-022 SHALL return the new data for a read issued the cycle after a write to the same address.
REQ-023 SHALL guarantee that the FIFO never overflows: REQ-013 reserves a slot for every inflight read.

Reset
REQ-024 SHALL set, while reset_n=0: count=0, inflight=0, resp_valid=0, req_ready=0, RW0_en=0, FIFO pointers=0; FIFO data need not be reset.
REQ-025 SHALL, on reset mid-operation, discard inflight reads and buffered responses without emitting them.
REQ-026 SHALL enter state INIT after reset release when ARRAY_CTRL_INIT_EN is defined, else state RUN.

Configuration
REQ-027 SHALL, with ARRAY_CTRL_INIT_EN defined, run an INIT→RUN state machine with an ADDR_W-bit counter from 0: each INIT cycle writes zero to address counter (RW0_en=1, RW0_wmode=1, RW0_wdata=0), increments the counter, and goes to RUN after address 2^ADDR_W-1.
REQ-028 SHALL, with ARRAY_CTRL_INIT_EN defined, hold init_done=0 in INIT and 1 in RUN; init_done first rises 2^ADDR_W cycles after reset release.
REQ-029 SHALL, without ARRAY_CTRL_INIT_EN, compile out the counter and state register and tie init_done=1.

Structure
REQ-030 SHALL place the ADDR_W/DATA_W defaults and the state enum {INIT, RUN} in package array_ctrl_pkg.
REQ-031 SHALL implement the response buffer as sub-module array_resp_fifo (push, pop, count, head data).

Verification
REQ-032 SHALL cover: init enabled, reset release → exactly 1024 zero-writes to addresses 0..1023 on consecutive cycles, then init_done=1 at cycle 1024; a read of 0x3FF returns 0x00000000.
REQ-033 SHALL cover: write 0x12345678 to 0x005, read 0x005 next cycle → resp_valid two cycles after the read fire, resp_rdata=0x12345678.
REQ-034 SHALL cover: 8 back-to-back reads of addresses 0..7 with resp_ready=1 → req_ready stays 1, 8 in-order responses on 8 consecutive cycles.
REQ-035 SHALL cover: resp_ready=0 while issuing reads → req_ready falls after 3 fires, with no overflow; releasing resp_ready drains 3 responses in order.
REQ-036 SHALL cover: read 0x010 (holding 0xAAAA0000), then write 0xBBBB0000 to 0x010 the next cycle → the response is 0xAAAA0000.
REQ-037 SHALL cover: reset_n pulsed low with 2 responses buffered and 1 inflight → resp_valid=0 immediately, and no stale response after re-init.
